// File: rtl/riscv_mult_arbiter.sv
// riscv_mult_arbiter
//   Lets two requesters share one riscv_mult instance. Each request is taken
//   over a valid/ready handshake and its fields are latched. The latched request
//   then drives the multiplier until mult_ready_i reports completion. MUL_H
//   completion arrives after its extra STEP0..STEP2/FINISH cycles. The captured
//   result goes back on the owning requester's response handshake.
//   Simultaneous requests are resolved round-robin.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   req{0,1}_valid_i/_ready_o      request handshake
//   req{0,1}_operator/signed/subword/imm/op_a/op_b/op_c_i   request fields
//   rsp{0,1}_valid_o/_ready_i      response handshake
//   rsp{0,1}_result_o              shared result register
//   mult_*_o                       latched request fields to the multiplier
//   mult_result_i, mult_ready_i    multiplier result and completion
//   mult_ex_ready_o                releases the multiplier once its result is taken
module riscv_mult_arbiter (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [2:0]  req0_operator_i,
  input  logic [1:0]  req0_signed_i,
  input  logic        req0_subword_i,
  input  logic [4:0]  req0_imm_i,
  input  logic [31:0] req0_op_a_i,
  input  logic [31:0] req0_op_b_i,
  input  logic [31:0] req0_op_c_i,
  output logic        rsp0_valid_o,
  output logic [31:0] rsp0_result_o,
  input  logic        rsp0_ready_i,

  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [2:0]  req1_operator_i,
  input  logic [1:0]  req1_signed_i,
  input  logic        req1_subword_i,
  input  logic [4:0]  req1_imm_i,
  input  logic [31:0] req1_op_a_i,
  input  logic [31:0] req1_op_b_i,
  input  logic [31:0] req1_op_c_i,
  output logic        rsp1_valid_o,
  output logic [31:0] rsp1_result_o,
  input  logic        rsp1_ready_i,

  output logic        mult_enable_o,
  output logic [2:0]  mult_operator_o,
  output logic        mult_short_subword_o,
  output logic [1:0]  mult_short_signed_o,
  output logic [1:0]  mult_dot_signed_o,
  output logic [4:0]  mult_imm_o,
  output logic [31:0] mult_op_a_o,
  output logic [31:0] mult_op_b_o,
  output logic [31:0] mult_op_c_o,
  input  logic [31:0] mult_result_i,
  input  logic        mult_ready_i,
  output logic        mult_ex_ready_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t      r_state, w_state_nxt;

  logic [2:0]  r_operator;
  logic [1:0]  r_signed;
  logic        r_subword;
  logic [4:0]  r_imm;
  logic [31:0] r_op_a, r_op_b, r_op_c;
  logic        r_grant_id;
  logic        r_last_grant;   // id of the most recent winner
  logic [31:0] r_result;

  logic        w_idle, w_busy, w_resp;
  logic        w_gnt0, w_gnt1, w_accept;
  logic        w_rsp_ready;

  assign w_idle = (r_state == S_IDLE);
  assign w_busy = (r_state == S_BUSY);
  assign w_resp = (r_state == S_RESP);

  // A lone requester always wins. On a tie, the requester that did not win last
  // time wins now.
  assign w_gnt0   = req0_valid_i & (~req1_valid_i | r_last_grant);
  assign w_gnt1   = req1_valid_i & (~req0_valid_i | ~r_last_grant);
  assign w_accept = w_idle & (w_gnt0 | w_gnt1);

  assign req0_ready_o = w_idle & w_gnt0;
  assign req1_ready_o = w_idle & w_gnt1;

  assign w_rsp_ready  = r_grant_id ? rsp1_ready_i : rsp0_ready_i;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)     w_state_nxt = S_BUSY;
      S_BUSY:  if (mult_ready_i) w_state_nxt = S_RESP;
      S_RESP:  if (w_rsp_ready)  w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_operator   <= '0;
      r_signed     <= '0;
      r_subword    <= 1'b0;
      r_imm        <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_c       <= '0;
      r_grant_id   <= 1'b0;
      r_last_grant <= 1'b1;
      r_result     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_operator   <= w_gnt1 ? req1_operator_i : req0_operator_i;
        r_signed     <= w_gnt1 ? req1_signed_i   : req0_signed_i;
        r_subword    <= w_gnt1 ? req1_subword_i  : req0_subword_i;
        r_imm        <= w_gnt1 ? req1_imm_i      : req0_imm_i;
        r_op_a       <= w_gnt1 ? req1_op_a_i     : req0_op_a_i;
        r_op_b       <= w_gnt1 ? req1_op_b_i     : req0_op_b_i;
        r_op_c       <= w_gnt1 ? req1_op_c_i     : req0_op_c_i;
        r_grant_id   <= w_gnt1;
        r_last_grant <= w_gnt1;
      end
      if (w_busy && mult_ready_i) r_result <= mult_result_i;
    end
  end

  // The multiplier sees the latched request at all times. Only enable and
  // ex_ready tell it when the request is live.
  assign mult_enable_o        = w_busy;
  assign mult_ex_ready_o      = w_busy & mult_ready_i;
  assign mult_operator_o      = r_operator;
  assign mult_short_subword_o = r_subword;
  assign mult_short_signed_o  = r_signed;
  assign mult_dot_signed_o    = r_signed;
  assign mult_imm_o           = r_imm;
  assign mult_op_a_o          = r_op_a;
  assign mult_op_b_o          = r_op_b;
  assign mult_op_c_o          = r_op_c;

  assign rsp0_valid_o  = w_resp & ~r_grant_id;
  assign rsp1_valid_o  = w_resp &  r_grant_id;
  assign rsp0_result_o = r_result;
  assign rsp1_result_o = r_result;

endmodule

// File: tb/tb_riscv_mult_arbiter.sv
// Directed bench for riscv_mult_arbiter. A small multiplier stand-in provides
// results for the operators used here. It holds MUL_H ready low for four enabled
// cycles and raises it in the fifth.
module tb_riscv_mult_arbiter;

  localparam logic [2:0] MUL_MAC32 = 3'b000;
  localparam logic [2:0] MUL_MSU32 = 3'b001;
  localparam logic [2:0] MUL_I     = 3'b010;
  localparam logic [2:0] MUL_H     = 3'b110;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid_i, req0_ready_o, req0_subword_i;
  logic [2:0]  req0_operator_i;
  logic [1:0]  req0_signed_i;
  logic [4:0]  req0_imm_i;
  logic [31:0] req0_op_a_i, req0_op_b_i, req0_op_c_i;
  logic        rsp0_valid_o, rsp0_ready_i;
  logic [31:0] rsp0_result_o;
  logic        req1_valid_i, req1_ready_o, req1_subword_i;
  logic [2:0]  req1_operator_i;
  logic [1:0]  req1_signed_i;
  logic [4:0]  req1_imm_i;
  logic [31:0] req1_op_a_i, req1_op_b_i, req1_op_c_i;
  logic        rsp1_valid_o, rsp1_ready_i;
  logic [31:0] rsp1_result_o;
  logic        mult_enable_o, mult_short_subword_o, mult_ex_ready_o;
  logic [2:0]  mult_operator_o;
  logic [1:0]  mult_short_signed_o, mult_dot_signed_o;
  logic [4:0]  mult_imm_o;
  logic [31:0] mult_op_a_o, mult_op_b_o, mult_op_c_o;
  logic [31:0] mult_result_i;
  logic        mult_ready_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_mult_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_operator_i(req0_operator_i), .req0_signed_i(req0_signed_i),
    .req0_subword_i(req0_subword_i), .req0_imm_i(req0_imm_i),
    .req0_op_a_i(req0_op_a_i), .req0_op_b_i(req0_op_b_i), .req0_op_c_i(req0_op_c_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_result_o(rsp0_result_o), .rsp0_ready_i(rsp0_ready_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_operator_i(req1_operator_i), .req1_signed_i(req1_signed_i),
    .req1_subword_i(req1_subword_i), .req1_imm_i(req1_imm_i),
    .req1_op_a_i(req1_op_a_i), .req1_op_b_i(req1_op_b_i), .req1_op_c_i(req1_op_c_i),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_result_o(rsp1_result_o), .rsp1_ready_i(rsp1_ready_i),
    .mult_enable_o(mult_enable_o), .mult_operator_o(mult_operator_o),
    .mult_short_subword_o(mult_short_subword_o),
    .mult_short_signed_o(mult_short_signed_o), .mult_dot_signed_o(mult_dot_signed_o),
    .mult_imm_o(mult_imm_o),
    .mult_op_a_o(mult_op_a_o), .mult_op_b_o(mult_op_b_o), .mult_op_c_o(mult_op_c_o),
    .mult_result_i(mult_result_i), .mult_ready_i(mult_ready_i),
    .mult_ex_ready_o(mult_ex_ready_o)
  );

  // Multiplier stand-in
  logic [2:0]  m_cnt;
  logic [63:0] m_ea, m_eb, m_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           m_cnt <= '0;
    else if (mult_ex_ready_o)                             m_cnt <= '0;
    else if (mult_enable_o && mult_operator_o == MUL_H)   m_cnt <= m_cnt + 3'd1;
  end

  always_comb begin
    m_ea   = {{32{mult_short_signed_o[0] & mult_op_a_o[31]}}, mult_op_a_o};
    m_eb   = {{32{mult_short_signed_o[1] & mult_op_b_o[31]}}, mult_op_b_o};
    m_prod = m_ea * m_eb;
    case (mult_operator_o)
      MUL_MAC32: mult_result_i = m_prod[31:0] + mult_op_c_o;
      MUL_MSU32: mult_result_i = mult_op_c_o - m_prod[31:0];
      MUL_H:     mult_result_i = m_prod[63:32];
      default:   mult_result_i = m_prod[31:0];
    endcase
    mult_ready_i = mult_enable_o & ((mult_operator_o != MUL_H) | (m_cnt == 3'd4));
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drive0(input logic v, input logic [2:0] op, input logic [1:0] sg,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    req0_valid_i = v; req0_operator_i = op; req0_signed_i = sg;
    req0_op_a_i = a; req0_op_b_i = b; req0_op_c_i = c;
  endtask

  task automatic drive1(input logic v, input logic [2:0] op, input logic [1:0] sg,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    req1_valid_i = v; req1_operator_i = op; req1_signed_i = sg;
    req1_op_a_i = a; req1_op_b_i = b; req1_op_c_i = c;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, mult_enable_o, mult_ex_ready_o} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000",
        {req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, mult_enable_o, mult_ex_ready_o});
    end
    checks++;
    if ({mult_op_a_o, mult_op_b_o, mult_op_c_o, rsp0_result_o, mult_operator_o, mult_imm_o} !== '0) begin
      errors++; $display("FAIL reset_data got a=%h b=%h c=%h res=%h", mult_op_a_o, mult_op_b_o, mult_op_c_o, rsp0_result_o);
    end
    tick; tick;
    rst_n = 1'b1;
    tick;
    // The first tie goes to requester 0. Valids are dropped before the edge, so nothing is accepted.
    drive0(1, MUL_I, 2'b00, 0, 0, 0);
    drive1(1, MUL_I, 2'b00, 0, 0, 0);
    #1;
    checks++;
    if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
      errors++; $display("FAIL first_tie got %b want 10", {req0_ready_o, req1_ready_o});
    end
    req0_valid_i = 0; req1_valid_i = 0;
    #1;
    checks++;
    if ({req0_ready_o, req1_ready_o} !== 2'b00) begin
      errors++; $display("FAIL ready_drop got %b want 00", {req0_ready_o, req1_ready_o});
    end
    tick;
  endtask

  task automatic test_mac32;
    drive0(1, MUL_MAC32, 2'b00, 3, 5, 7);
    #1;
    checks++;
    if (req0_ready_o !== 1'b1 || mult_enable_o !== 1'b0) begin
      errors++; $display("FAIL mac_accept got rdy=%b en=%b want 1 0", req0_ready_o, mult_enable_o);
    end
    tick;
    drive0(0, MUL_MAC32, 2'b00, 0, 0, 0);  // operands only needed in the accept cycle
    #1;
    checks++;
    if (mult_enable_o !== 1'b1 || mult_ex_ready_o !== 1'b1 || mult_op_a_o !== 32'd3 ||
        mult_op_c_o !== 32'd7 || rsp0_valid_o !== 1'b0) begin
      errors++; $display("FAIL mac_busy got en=%b exr=%b a=%h c=%h rv=%b want 1 1 3 7 0",
        mult_enable_o, mult_ex_ready_o, mult_op_a_o, mult_op_c_o, rsp0_valid_o);
    end
    tick;
    #1;
    checks++;
    if (rsp0_valid_o !== 1'b1 || rsp1_valid_o !== 1'b0 || rsp0_result_o !== 32'd22 || mult_enable_o !== 1'b0) begin
      errors++; $display("FAIL mac_resp got v0=%b v1=%b res=%0d en=%b want 1 0 22 0",
        rsp0_valid_o, rsp1_valid_o, rsp0_result_o, mult_enable_o);
    end
    rsp0_ready_i = 1;
    tick;
    rsp0_ready_i = 0;
    #1;
    checks++;
    if (rsp0_valid_o !== 1'b0 || mult_enable_o !== 1'b0) begin
      errors++; $display("FAIL mac_done got v0=%b en=%b want 0 0", rsp0_valid_o, mult_enable_o);
    end
  endtask

  task automatic test_mulh;
    drive1(1, MUL_H, 2'b11, 32'h8000_0000, 32'h8000_0000, 0);
    #1;
    checks++;
    if (req1_ready_o !== 1'b1) begin
      errors++; $display("FAIL mulh_accept got %b want 1", req1_ready_o);
    end
    tick;
    drive1(0, MUL_I, 2'b00, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (mult_enable_o !== 1'b1 || mult_ex_ready_o !== (i == 4) || rsp1_valid_o !== 1'b0) begin
        errors++; $display("FAIL mulh_busy%0d got en=%b exr=%b rv=%b want 1 %0d 0",
          i, mult_enable_o, mult_ex_ready_o, rsp1_valid_o, (i == 4));
      end
      tick;
    end
    #1;
    checks++;
    if (rsp1_valid_o !== 1'b1 || rsp0_valid_o !== 1'b0 || rsp1_result_o !== 32'h4000_0000 || mult_enable_o !== 1'b0) begin
      errors++; $display("FAIL mulh_resp got v1=%b v0=%b res=%h en=%b want 1 0 40000000 0",
        rsp1_valid_o, rsp0_valid_o, rsp1_result_o, mult_enable_o);
    end
    rsp1_ready_i = 1;
    tick;
    rsp1_ready_i = 0;
  endtask

  task automatic test_back_to_back;
    drive0(1, MUL_I, 2'b00, 2, 3, 0);
    drive1(1, MUL_I, 2'b00, 2, 3, 0);
    rsp0_ready_i = 1; rsp1_ready_i = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({req1_ready_o, req0_ready_o} !== ((k % 2) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rr_grant%0d got r1r0=%b want %b", k, {req1_ready_o, req0_ready_o},
          ((k % 2) ? 2'b10 : 2'b01));
      end
      tick;
      #1;
      checks++;
      if (mult_enable_o !== 1'b1 || req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0) begin
        errors++; $display("FAIL rr_busy%0d got en=%b r0=%b r1=%b want 1 0 0", k, mult_enable_o, req0_ready_o, req1_ready_o);
      end
      tick;
      #1;
      checks++;
      if ({rsp1_valid_o, rsp0_valid_o} !== ((k % 2) ? 2'b10 : 2'b01) || rsp0_result_o !== 32'd6) begin
        errors++; $display("FAIL rr_resp%0d got v1v0=%b res=%0d want %b 6", k, {rsp1_valid_o, rsp0_valid_o},
          rsp0_result_o, ((k % 2) ? 2'b10 : 2'b01));
      end
      tick;
    end
    req0_valid_i = 0; req1_valid_i = 0;
    rsp0_ready_i = 0; rsp1_ready_i = 0;
    #1;
  endtask

  task automatic test_hold;
    drive0(1, MUL_I, 2'b00, 4, 5, 0);
    tick;
    req0_valid_i = 0;
    tick;
    drive1(1, MUL_MAC32, 2'b00, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rsp0_valid_o !== 1'b1 || rsp0_result_o !== 32'd20 || req1_ready_o !== 1'b0) begin
        errors++; $display("FAIL hold%0d got v0=%b res=%0d r1rdy=%b want 1 20 0", i, rsp0_valid_o, rsp0_result_o, req1_ready_o);
      end
      tick;
    end
    rsp0_ready_i = 1;
    #1;
    checks++;
    if (req1_ready_o !== 1'b0 || rsp0_valid_o !== 1'b1) begin
      errors++; $display("FAIL hold_consume got r1rdy=%b v0=%b want 0 1", req1_ready_o, rsp0_valid_o);
    end
    tick;
    rsp0_ready_i = 0;
    #1;
    checks++;
    if (req1_ready_o !== 1'b1 || rsp0_valid_o !== 1'b0) begin
      errors++; $display("FAIL hold_after got r1rdy=%b v0=%b want 1 0", req1_ready_o, rsp0_valid_o);
    end
    req1_valid_i = 0;
    tick;
  endtask

  task automatic test_reset_mid_op;
    drive1(1, MUL_H, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h1234);
    tick;
    req1_valid_i = 0;
    tick; tick;
    rst_n = 0;  // third BUSY cycle
    #1;
    checks++;
    if ({req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, mult_enable_o, mult_ex_ready_o} !== 6'b0 ||
        mult_op_a_o !== 32'd0 || mult_op_c_o !== 32'd0 || mult_operator_o !== 3'd0 || rsp1_result_o !== 32'd0) begin
      errors++; $display("FAIL midreset got ctl=%b a=%h c=%h op=%0d res=%h want 0",
        {req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, mult_enable_o, mult_ex_ready_o},
        mult_op_a_o, mult_op_c_o, mult_operator_o, rsp1_result_o);
    end
    tick;
    rst_n = 1;
    tick;
    drive0(1, MUL_H, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    #1;
    checks++;
    if (req0_ready_o !== 1'b1) begin
      errors++; $display("FAIL mulhu_accept got %b want 1", req0_ready_o);
    end
    tick;
    req0_valid_i = 0;
    for (int i = 0; i < 5; i++) tick;
    #1;
    checks++;
    if (rsp0_valid_o !== 1'b1 || rsp0_result_o !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL mulhu_resp got v0=%b res=%h want 1 fffffffe", rsp0_valid_o, rsp0_result_o);
    end
    rsp0_ready_i = 1;
    tick;
    rsp0_ready_i = 0;
  endtask

  initial begin
    rst_n = 0;
    drive0(0, 3'd0, 2'b00, 0, 0, 0);
    drive1(0, 3'd0, 2'b00, 0, 0, 0);
    req0_subword_i = 0; req1_subword_i = 0;
    req0_imm_i = 0; req1_imm_i = 0;
    rsp0_ready_i = 0; rsp1_ready_i = 0;
    test_reset;
    test_mac32;
    test_mulh;
    test_back_to_back;
    test_hold;
    test_reset_mid_op;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_mult_arbiter.md
# riscv_mult_arbiter

Shares one `riscv_mult` instance between two requesters, for example the core EX stage and an accelerator/coprocessor port. Each request is accepted over a valid/ready handshake and its operands are latched. The latched request drives the multiplier until `ready` indicates completion, which also covers the 4-extra-cycle MUL_H sequence. The result is then returned on a per-requester response handshake, and round-robin arbitration resolves simultaneous requests.

## Interface
Parameters:
- none. Operator codes (MUL_MAC32, MUL_MSU32, MUL_I, MUL_IR, MUL_H, MUL_DOT8, MUL_DOT16) come from `riscv_defines.sv`.

Ports (`x` ∈ {0,1}, one set per requester):
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `reqx_valid_i`  in  1  request pending.
- `reqx_ready_o`  out  1  request accepted this cycle.
- `reqx_operator_i`  in  3  multiplier operator.
- `reqx_signed_i`  in  2  short/dot signedness.
- `reqx_subword_i`  in  1  short subword select.
- `reqx_imm_i`  in  5  shift/round immediate.
- `reqx_op_a_i`, `reqx_op_b_i`, `reqx_op_c_i`  in  32 each  operands.
- `rspx_valid_o`  out  1  result available.
- `rspx_result_o`  out  32  result.
- `rspx_ready_i`  in  1  result consumed.
- `mult_enable_o`  out  1  to multiplier `enable_i`.
- `mult_operator_o`  out  3  to multiplier `operator_i`.
- `mult_short_subword_o`  out  1  to multiplier `short_subword_i`.
- `mult_short_signed_o`, `mult_dot_signed_o`  out  2 each  both driven from the latched `signed` field.
- `mult_imm_o`  out  5  to multiplier `imm_i`.
- `mult_op_a_o`, `mult_op_b_o`, `mult_op_c_o`  out  32 each  drive both the short and the dot operand ports.
- `mult_result_i`  in  32  from multiplier `result_o`.
- `mult_ready_i`  in  1  from multiplier `ready_o`.
- `mult_ex_ready_o`  out  1  to multiplier `ex_ready_i`.

## Operation
FSM states are IDLE, BUSY and RESP. The reset state is IDLE.

- **IDLE**
  - Grant logic is combinational from the two valids.
  - With one valid, that requester is granted.
  - With both valid, the requester not granted last is granted.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - `reqx_ready_o` = IDLE & granted(x).
  - On accept: latch operator/signed/subword/imm/op_a/op_b/op_c, record `grant_id`, update `last_grant`, go to BUSY.
- **BUSY**
  - `mult_enable_o` = 1; the mult_* outputs show the latched fields.
  - `mult_ex_ready_o` = BUSY & `mult_ready_i`.
  - When `mult_ready_i` = 1: capture `mult_result_i` into the result register and go to RESP.
  - For MUL_H, the multiplier holds ready low through STEP0..STEP2, and the FINISH cycle raises ready. Asserting `mult_ex_ready_o` in FINISH returns the multiplier to IDLE and clears its carry.
  - Any other operator completes in the first BUSY cycle.
- **RESP**
  - `rsp[grant_id]_valid_o` = 1; the other requester's `rsp_valid_o` = 0.
  - `rspx_result_o` shows the result register. The other requester's `rspx_result_o` also shows it but must be ignored.
  - `mult_enable_o` = 0.
  - When `rsp[grant_id]_ready_i` = 1: go to IDLE.
  - No request is accepted in RESP or BUSY.
- Unknown operator codes are treated as single-cycle. The result is whatever the multiplier returns.
- **Reset mid-operation:** the FSM goes to IDLE immediately and all registers clear. The multiplier shares `rst_n`, so its MUL_H state and carry clear too.

## Timing
- **Reset values:** every `req*_ready_o`, `rsp*_valid_o` and `mult_enable_o` = 0; `mult_ex_ready_o` = 0. All latched fields, result registers and mult_* operand outputs = 0, and `last_grant` = 1.
- **Single-cycle operator accepted at edge T:**
  - BUSY in cycle T+1, with `mult_enable_o` and `mult_ex_ready_o` high.
  - `rsp_valid_o` rises in T+2.
- **MUL_H accepted at T:**
  - BUSY for cycles T+1..T+5; `mult_ready_i` is low T+1..T+4 and high in T+5 (FINISH).
  - `mult_ex_ready_o` high only in T+5.
  - `rsp_valid_o` in T+6.
- **Response and back-to-back requests:**
  - `rsp_valid_o` and `rspx_result_o` stay stable until consumed.
  - Earliest next accept is the cycle after the consume, so single-cycle throughput is 1 op / 3 cycles.
- **Handshake rules:**
  - Requesters may drop or change `req_valid_i` at any time before accept.
  - Operands only need to be valid in the accept cycle.

## Test plan
- Requester 0, MUL_MAC32, a=3, b=5, c=7, accepted at T -> `rsp0_valid_o` in T+2 with result 22; `rsp1_valid_o` stays 0; `mult_enable_o` high only in T+1.
- Requester 1, MUL_H, signed=2'b11, a=b=0x80000000 -> `mult_enable_o` high T+1..T+5; `mult_ex_ready_o` high only in T+5; `rsp1_result_o` = 0x40000000 in T+6.
- Both requesters continuously valid with MUL_I a=2, b=3, c=0, `rsp_ready` tied high -> accepts alternate r0, r1, r0, r1, starting with r0; every result = 6.
- `rsp0_ready_i` held low 3 cycles after a response -> `rsp0_valid_o` and the result are held; `req1_valid_i` = 1 sees `req1_ready_o` = 0 until the cycle after consume.
- `rst_n` pulsed low during the 3rd BUSY cycle of a MUL_H -> all outputs read 0 immediately. After reset, MULHU (signed 2'b00) with a=b=0xFFFFFFFF returns 0xFFFFFFFE, confirming no stale carry.
